jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
Shared controller for a bank of WIDTH JK flip-flops, arbitrated among N_REQ requesters. Each requester posts a JK command (hold/reset/set/toggle) with a per-bit mask. A round-robin arbiter grants one command at a time. A 3-state sequencer drives the J/K inputs for exactly one clock and then reports completion with the updated bank state. It sits between the JKFF datapath and the control logic that previously drove j_i/k_i directly.

Parameters:
N_REQ, 4, number of requesters (>= 2).
WIDTH, 8, number of JK flip-flops in the bank (>= 1).
IDW, $clog2(N_REQ), width of requester index (derived localparam, not overridable).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req_i  input  N_REQ  per-requester request; held high until the matching gnt_o bit pulses.
cmd_i  input  2*N_REQ  per-requester command; requester r uses bits [2r+1:2r].
mask_i  input  WIDTH*N_REQ  per-requester bit mask; requester r uses bits [WIDTH*r +: WIDTH].
gnt_o  output  N_REQ  one-hot grant pulse, 1 cycle.
busy_o  output  1  high whenever state != IDLE.
done_o  output  1  1-cycle completion pulse.
done_id_o  output  IDW  index of the requester whose command completed; valid while done_o is high.
q_o  output  WIDTH  current bank contents (JK flip-flop Q outputs).

Behaviour:
- Reset (async, rst=1): state=IDLE, q_o=0, gnt_o=0, done_o=0, done_id_o=0, busy_o=0, rr pointer=0, captured cmd/mask=0.
- Command encoding (JK convention): HOLD=2'b00 (j=0,k=0), RESET=2'b01 (j=0,k=1), SET=2'b10 (j=1,k=0), TOGGLE=2'b11 (j=1,k=1).
- Per-bit drive during APPLY only:
  - j[b] = mask[b] & cmd[1]
  - k[b] = mask[b] & cmd[0]
  - In every other state j=k=0 (bank holds).
- Bank update on each rising edge: q <= (j & ~q) | (~k & q).
- FSM states IDLE, APPLY, DONE:
  - IDLE: if any req_i is high, select a winner r by round-robin starting at the rr pointer and wrapping from N_REQ-1 to 0. Capture cmd_i[r], mask_i[r], and r. Pulse gnt_o[r] in this same cycle (combinational from IDLE & winner). Next state is APPLY. If no req_i is high, stay in IDLE.
  - APPLY: drive j/k from the captured cmd/mask for one cycle; the bank updates at the end of this cycle. Next state is DONE. Set rr pointer = (r+1) mod N_REQ.
  - DONE: done_o=1, done_id_o=r, q_o already shows the updated value. Next state is IDLE.
- Latency: grant in cycle T, bank update at the edge ending T+1, done_o in T+2. Maximum throughput is one command per 3 cycles.
- req_i is sampled only in IDLE. Requests arriving in APPLY or DONE wait. A requester that keeps req_i high after its grant is treated as a new request at the next IDLE; it gets normal round-robin priority, so there is no starvation.
- Changes to cmd_i/mask_i after the grant have no effect; the captured values are used.
- mask=0 or cmd=HOLD: full 3-cycle sequence runs; q_o is unchanged; done_o still pulses.
- Reset mid-operation: an asserted rst in APPLY or DONE aborts immediately with no done_o. A bank update that would have occurred at that edge is discarded (q=0).

Decomposition:
- Package jk_ctrl_pkg:
  - cmd typedef jk_cmd_e {HOLD, RESET, SET, TOGGLE} with the 2-bit encoding above.
  - state typedef jk_arb_state_e {IDLE, APPLY, DONE}.
- Sub-module jk_bank: WIDTH JK flip-flops with inputs clk, rst, j[WIDTH], k[WIDTH] and output q[WIDTH], async reset to 0. Arbiter and FSM stay in jk_bank_arbiter.

Test Plan:
- Reset check: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; busy_o=0.
- Single SET: req_i=4'b0001, cmd=SET, mask=8'h0F, q=0 -> gnt_o=4'b0001 at T, q_o=8'h0F at T+2 with done_o=1 and done_id_o=0.
- Toggle pair: from q=8'h0F, requester 2 issues TOGGLE with mask=8'hFF twice -> q_o=8'hF0 after the first command, 8'h0F after the second; each done_id_o=2.
- Contention: req_i=4'b1111 held high, each requester issuing SET of its own bit -> grants in order 0,1,2,3,0, each 3 cycles apart; q_o=8'h0F after the fourth done.
- HOLD / zero mask: requester 1 issues HOLD with mask=8'hFF, then RESET with mask=8'h00 -> q_o unchanged; done_o pulses twice with done_id_o=1.
- Reset in APPLY: grant SET mask=8'hFF, assert rst during APPLY -> q_o=0, no done_o, state IDLE, rr pointer=0.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank controller: command encoding, sequencer states
// and the JK next-state helper.
package jk_ctrl_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      RESET  = 2'b01,
      SET    = 2'b10,
      TOGGLE = 2'b11
   } jk_cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      APPLY = 2'b01,
      DONE  = 2'b10
   } jk_arb_state_e;

   // Classic JK characteristic equation, one bit.
   function automatic logic jk_next(input logic j, input logic k, input logic q);
      return (j & ~q) | (~k & q);
   endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with asynchronous active-high clear.
module jk_bank
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      for (int b = 0; b < WIDTH; b++) begin
         q_d[b] = jk_next(j[b], k[b], q_q[b]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter plus IDLE/APPLY/DONE sequencer that applies one masked
// JK command per grant to a shared jk_bank.
module jk_bank_arbiter
   import jk_ctrl_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [2*N_REQ-1:0]     cmd_i,
   input  logic [WIDTH*N_REQ-1:0] mask_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [IDW-1:0]         done_id_o,
   output logic [WIDTH-1:0]       q_o
);

   jk_arb_state_e    state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   jk_cmd_e          cmd_q, cmd_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [IDW-1:0]   id_q, id_d;

   jk_cmd_e          cmd_arr [N_REQ];
   logic [WIDTH-1:0] mask_arr [N_REQ];
   logic             win_vld;
   logic [IDW-1:0]   win_id;
   logic [WIDTH-1:0] j_drv;
   logic [WIDTH-1:0] k_drv;

   for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
      assign cmd_arr[r]  = jk_cmd_e'(cmd_i[2*r+1 -: 2]);
      assign mask_arr[r] = mask_i[WIDTH*r +: WIDTH];
   end

   // Requester index reached by stepping 'off' places past the pointer, with wrap.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
      int idx;
      idx = int'(base) + off;
      idx = (idx >= N_REQ) ? idx - N_REQ : idx;
      return IDW'(idx);
   endfunction

   // Round-robin search: first active request at or after the pointer.
   always_comb begin
      win_vld = 1'b0;
      win_id  = {IDW{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_vld && req_i[rr_index(rr_q, i)]) begin
            win_vld = 1'b1;
            win_id  = rr_index(rr_q, i);
         end else begin
            win_vld = win_vld;
         end
      end
   end

   // Sequencer next state, command capture and grant pulse.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cmd_d   = cmd_q;
      mask_d  = mask_q;
      id_d    = id_q;
      gnt_o   = {N_REQ{1'b0}};
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d        = APPLY;
               cmd_d          = cmd_arr[win_id];
               mask_d         = mask_arr[win_id];
               id_d           = win_id;
               gnt_o[win_id]  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         APPLY: begin
            state_d = DONE;
            rr_d    = (id_q == IDW'(N_REQ - 1)) ? {IDW{1'b0}} : id_q + IDW'(1);
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer and captured-command registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= {IDW{1'b0}};
         cmd_q   <= HOLD;
         mask_q  <= {WIDTH{1'b0}};
         id_q    <= {IDW{1'b0}};
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cmd_q   <= cmd_d;
         mask_q  <= mask_d;
         id_q    <= id_d;
      end
   end

   // J/K are driven only in APPLY; the bank holds in every other state.
   always_comb begin
      j_drv = {WIDTH{1'b0}};
      k_drv = {WIDTH{1'b0}};
      if (state_q == APPLY) begin
         j_drv = mask_q & {WIDTH{cmd_q[1]}};
         k_drv = mask_q & {WIDTH{cmd_q[0]}};
      end else begin
         j_drv = {WIDTH{1'b0}};
         k_drv = {WIDTH{1'b0}};
      end
   end

   jk_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk (clk),
      .rst (rst),
      .j   (j_drv),
      .k   (k_drv),
      .q   (q_o)
   );

   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);
   assign done_id_o = (state_q == DONE) ? id_q : {IDW{1'b0}};

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and randomized bench for jk_bank_arbiter against a set/clear/flip
// reference model of the bank and a round-robin winner search.
module tb_jk_bank_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_i;
   logic [2*N-1:0]   cmd_i;
   logic [W*N-1:0]   mask_i;
   logic [N-1:0]     gnt_o;
   logic             busy_o;
   logic             done_o;
   logic [IDW-1:0]   done_id_o;
   logic [W-1:0]     q_o;

   int vectors;
   int miscompares;

   logic [W-1:0] q_m;
   int           rr_m;

   jk_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .cmd_i     (cmd_i),
      .mask_i    (mask_i),
      .gnt_o     (gnt_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .done_id_o (done_id_o),
      .q_o       (q_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full grant/apply/done transaction; req must be nonzero.
   task automatic txn(input logic [N-1:0] req, input logic [2*N-1:0] cmd, input logic [W*N-1:0] mask);
      int           w;
      logic [1:0]   c;
      logic [W-1:0] m;
      logic [N-1:0] g;
      w = -1;
      for (int i = 0; i < N; i++) begin
         if (w < 0 && req[(rr_m + i) % N]) w = (rr_m + i) % N;
      end
      g = '0;
      g[w] = 1'b1;
      c = cmd[2*w +: 2];
      m = mask[W*w +: W];
      @(negedge clk);
      req_i = req; cmd_i = cmd; mask_i = mask;
      #1;
      check("idle_gnt", 32'(gnt_o), 32'(g));
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_q", 32'(q_o), 32'(q_m));
      @(negedge clk);
      cmd_i = 8'($urandom); mask_i = $urandom;
      #1;
      check("apply_gnt", 32'(gnt_o), 32'd0);
      check("apply_busy", 32'(busy_o), 32'd1);
      check("apply_done", 32'(done_o), 32'd0);
      case (c)
         2'b01:   q_m = q_m & ~m;
         2'b10:   q_m = q_m | m;
         2'b11:   q_m = q_m ^ m;
         default: q_m = q_m;
      endcase
      rr_m = (w + 1) % N;
      @(negedge clk);
      #1;
      check("done_pulse", 32'(done_o), 32'd1);
      check("done_id", 32'(done_id_o), 32'(w));
      check("done_q", 32'(q_o), 32'(q_m));
      check("done_gnt", 32'(gnt_o), 32'd0);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      req_i = '0; cmd_i = 8'($urandom); mask_i = $urandom;
      #1;
      check("noreq_gnt", 32'(gnt_o), 32'd0);
      check("noreq_busy", 32'(busy_o), 32'd0);
      check("noreq_done", 32'(done_o), 32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b0; req_i = '0; cmd_i = '0; mask_i = '0;
      q_m = '0; rr_m = 0;

      // Reset asserted between edges: outputs clear with no clock.
      #2 rst = 1'b1;
      #1;
      check("rst_q", 32'(q_o), 32'd0);
      check("rst_gnt", 32'(gnt_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_done_id", 32'(done_id_o), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Single SET from requester 0.
      txn(4'b0001, {2'b00, 2'b00, 2'b00, 2'b10}, {8'h00, 8'h00, 8'h00, 8'h0F});
      // Toggle pair from requester 2.
      txn(4'b0100, {2'b00, 2'b11, 2'b00, 2'b00}, {8'h00, 8'hFF, 8'h00, 8'h00});
      txn(4'b0100, {2'b00, 2'b11, 2'b00, 2'b00}, {8'h00, 8'hFF, 8'h00, 8'h00});
      // HOLD with full mask, then RESET with empty mask, requester 1.
      txn(4'b0010, {2'b00, 2'b00, 2'b00, 2'b00}, {8'h00, 8'h00, 8'hFF, 8'h00});
      txn(4'b0010, {2'b00, 2'b00, 2'b01, 2'b00}, {8'h00, 8'h00, 8'h00, 8'h00});
      check("hold_q", 32'(q_o), 32'h0F);
      idle_cycle();

      // Reset during APPLY discards the update and the done pulse.
      @(negedge clk);
      req_i = 4'b0100; cmd_i = {2'b00, 2'b10, 2'b00, 2'b00}; mask_i = {8'h00, 8'hFF, 8'h00, 8'h00};
      #1;
      check("abort_gnt", 32'(gnt_o), 32'b0100);
      @(posedge clk);
      #2 rst = 1'b1; req_i = '0;
      #1;
      check("abort_q", 32'(q_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      q_m = '0; rr_m = 0;

      // Contention: all requesting, each sets its own bit; rr restarts at 0.
      for (int n = 0; n < 5; n++) begin
         txn(4'b1111, {2'b10, 2'b10, 2'b10, 2'b10}, {8'h08, 8'h04, 8'h02, 8'h01});
         if (n == 3) check("contend_q4", 32'(q_o), 32'h0F);
      end

      // Randomized traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         logic [N-1:0] r;
         r = 4'($urandom_range(0, 15));
         if (r == '0) idle_cycle();
         else txn(r, 8'($urandom), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
